// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   Serial front end for the Arduino-to-elevator-controller link. Oversamples
//   the asynchronous rx line, recovers 8N1 bytes LSB-first and hands each
//   good byte to the frame assembler with a one-cycle receive_all strobe.
//   Majority-vote sampling, false-start rejection and framing-error
//   reporting keep line noise from corrupting the downstream byte count.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   en           1 = accept new start bits while idle
//   rx           asynchronous serial line, idle high
//   data         last correctly framed byte
//   receive_all  one-cycle strobe: data updated this cycle
//   frame_error  one-cycle strobe: stop bit sampled low
//   busy         high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int CLKFRQ     = 100000000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       receive_all,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV_RAW = CLKFRQ / (BAUDRATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(OVERSAMPLE + 1);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SC_LO    = SW'(M - 1);
  localparam logic [SW-1:0] SC_MID   = SW'(M);
  localparam logic [SW-1:0] SC_HI    = SW'(M + 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BRK_LAST = BW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_rx_meta;
  logic            r_rxs;
  logic            r_rxs_prev;
  logic [DW-1:0]   r_div;
  logic [SW-1:0]   r_sc;
  logic [2:0]      r_bit_idx;
  logic [BW-1:0]   r_brk_cnt;
  logic            r_s0;
  logic            r_s1;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_receive_all;
  logic            r_frame_error;

  logic            w_fall;
  logic            w_start;
  logic            w_tick;
  logic            w_decide;
  logic            w_bit_end;
  logic            w_maj;
  logic            w_rx_done;
  logic            w_fe;
  logic            w_shift_en;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // All flops reset to the idle-high line level so release never fakes a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta  <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_rx_meta  <= rx;
      r_rxs      <= r_rx_meta;
      r_rxs_prev <= r_rxs;
    end
  end

  assign w_fall  = r_rxs_prev & ~r_rxs;
  assign w_start = (r_state == S_IDLE) & en & w_fall;

  // Tick divider; restarted on start detection so the sample grid is
  // phase-locked to the falling edge of the start bit.
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_start || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Sample counter within a bit. On a tick, rxs is sampled for the current
  // sc value and sc then advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sc <= '0;
    end else if (w_start) begin
      r_sc <= '0;
    end else if (w_tick) begin
      r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;
    end
  end

  assign w_decide  = w_tick & (r_sc == SC_HI);
  assign w_bit_end = w_tick & (r_sc == SC_LAST);

  // First two majority samples are held; the third is the live rxs at the
  // decision tick.
  always_ff @(posedge clk) begin
    if (w_tick && (r_sc == SC_LO)) r_s0 <= r_rxs;
    if (w_tick && (r_sc == SC_MID)) r_s1 <= r_rxs;
  end

  assign w_maj = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. The stop bit is judged at mid-bit so the receiver is
  // back in IDLE half a bit early, ready for a back-to-back start edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_START;
      S_START: begin
        if (w_decide && w_maj) w_next = S_IDLE;
        else if (w_bit_end)    w_next = S_DATA;
      end
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_decide) w_next = w_maj ? S_IDLE : S_BREAK;
      S_BREAK: if (w_tick && r_rxs && (r_brk_cnt == BRK_LAST)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / datapath enables
  always_comb begin
    w_rx_done  = 1'b0;
    w_fe       = 1'b0;
    w_shift_en = 1'b0;
    case (r_state)
      S_DATA: w_shift_en = w_decide;
      S_STOP: begin
        w_rx_done = w_decide & w_maj;
        w_fe      = w_decide & ~w_maj;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Bit index and break-recovery counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_idx <= '0;
      r_brk_cnt <= '0;
    end else begin
      if (r_state == S_START && w_bit_end) begin
        r_bit_idx <= '0;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      // Any low sample while in BREAK restarts the full-bit idle wait.
      if (w_fe) begin
        r_brk_cnt <= '0;
      end else if (r_state == S_BREAK && w_tick) begin
        r_brk_cnt <= r_rxs ? r_brk_cnt + 1'b1 : '0;
      end
    end
  end

  // LSB-first shift register
  always_ff @(posedge clk) begin
    if (w_shift_en) r_shift <= {w_maj, r_shift[7:1]};
  end

  // Registered strobes; data and receive_all change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data        <= 8'h00;
      r_receive_all <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_receive_all <= w_rx_done;
      r_frame_error <= w_fe;
      if (w_rx_done) r_data <= r_shift;
    end
  end

  assign data        = r_data;
  assign receive_all = r_receive_all;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  localparam int BIT = 160;

  logic       clk;
  logic       reset;
  logic       en;
  logic       rx;
  logic [7:0] data;
  logic       receive_all;
  logic       frame_error;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  int n_rx = 0;
  int n_fe = 0;
  int n_both = 0;
  int n_strobe_busy = 0;

  uart_rx_sampler #(
    .CLKFRQ    (1600000),
    .BAUDRATE  (10000),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rx         (rx),
    .data       (data),
    .receive_all(receive_all),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (receive_all) n_rx <= n_rx + 1;
      if (frame_error) n_fe <= n_fe + 1;
      if (receive_all && frame_error) n_both <= n_both + 1;
      if (receive_all && busy) n_strobe_busy <= n_strobe_busy + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame: start, 8 data bits LSB-first, stop. glitch_bit >= 0 inverts rx
  // for one clock in the middle of that data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int glitch_bit);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_v;
      else             v = b[i-1];
      rx = v;
      if (i == glitch_bit + 1) begin
        wait_clk(80);
        rx = ~v;
        wait_clk(1);
        rx = v;
        wait_clk(BIT - 81);
      end else begin
        wait_clk(BIT);
      end
    end
    rx = 1'b1;
  endtask

  int base_rx;
  int base_fe;

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    rx    = 1'b1;
    wait_clk(3);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_rxall", {31'd0, receive_all}, 32'd0);
    chk("rst_fe", {31'd0, frame_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    wait_clk(BIT);

    // 0xA5, with busy observed mid-frame
    base_rx = n_rx;
    fork
      send_byte(8'hA5, 1'b1, -1);
      begin
        wait_clk(500);
        chk("a5_busy_mid", {31'd0, busy}, 32'd1);
      end
    join
    chk("a5_count", n_rx - base_rx, 32'd1);
    chk("a5_data", {24'd0, data}, 32'hA5);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    wait_clk(BIT);

    // Back-to-back 0x00 then 0xFF
    base_rx = n_rx;
    send_byte(8'h00, 1'b1, -1);
    chk("b2b_first_count", n_rx - base_rx, 32'd1);
    chk("b2b_first_data", {24'd0, data}, 32'h00);
    send_byte(8'hFF, 1'b1, -1);
    chk("b2b_second_count", n_rx - base_rx, 32'd2);
    chk("b2b_second_data", {24'd0, data}, 32'hFF);
    wait_clk(BIT);

    // 30-clk false start
    base_rx = n_rx;
    rx = 1'b0;
    wait_clk(20);
    chk("fs_busy_high", {31'd0, busy}, 32'd1);
    wait_clk(10);
    rx = 1'b1;
    wait_clk(BIT - 30);
    chk("fs_busy_low", {31'd0, busy}, 32'd0);
    wait_clk(BIT);
    chk("fs_no_strobe", n_rx - base_rx, 32'd0);

    // 1-clk glitch inside data bit 3 of 0x3C
    base_rx = n_rx;
    send_byte(8'h3C, 1'b1, 3);
    chk("glitch_count", n_rx - base_rx, 32'd1);
    chk("glitch_data", {24'd0, data}, 32'h3C);
    wait_clk(BIT);

    // Framing error followed by a long break
    base_rx = n_rx;
    base_fe = n_fe;
    send_byte(8'h5A, 1'b0, -1);
    rx = 1'b0;
    wait_clk(20 * BIT);
    rx = 1'b1;
    chk("fe_count", n_fe - base_fe, 32'd1);
    chk("fe_no_rx", n_rx - base_rx, 32'd0);
    chk("fe_data_kept", {24'd0, data}, 32'h3C);
    chk("fe_busy_in_break", {31'd0, busy}, 32'd1);
    wait_clk(3 * BIT);
    chk("fe_busy_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h11, 1'b1, -1);
    chk("fe_recover_count", n_rx - base_rx, 32'd1);
    chk("fe_recover_data", {24'd0, data}, 32'h11);
    chk("fe_single", n_fe - base_fe, 32'd1);
    wait_clk(BIT);

    // Reset during data bit 4 of 0x77, held until the frame is over
    base_rx = n_rx;
    fork
      send_byte(8'h77, 1'b1, -1);
      begin
        wait_clk(5 * BIT + 80);
        reset = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_data", {24'd0, data}, 32'h00);
        chk("mrst_rxall", {31'd0, receive_all}, 32'd0);
        chk("mrst_fe", {31'd0, frame_error}, 32'd0);
      end
    join
    wait_clk(BIT);
    reset = 1'b1;
    wait_clk(BIT);
    chk("mrst_no_strobe", n_rx - base_rx, 32'd0);
    send_byte(8'h42, 1'b1, -1);
    chk("mrst_next_count", n_rx - base_rx, 32'd1);
    chk("mrst_next_data", {24'd0, data}, 32'h42);
    wait_clk(BIT);

    // en = 0: start bits ignored
    base_rx = n_rx;
    en = 1'b0;
    fork
      send_byte(8'h99, 1'b1, -1);
      begin
        wait_clk(3 * BIT);
        chk("en0_busy", {31'd0, busy}, 32'd0);
      end
    join
    wait_clk(BIT);
    chk("en0_no_strobe", n_rx - base_rx, 32'd0);
    chk("en0_data_kept", {24'd0, data}, 32'h42);

    // en dropped during data bit 2 does not abort the frame
    en = 1'b1;
    fork
      send_byte(8'h99, 1'b1, -1);
      begin
        wait_clk(3 * BIT + 40);
        en = 1'b0;
      end
    join
    chk("endrop_count", n_rx - base_rx, 32'd1);
    chk("endrop_data", {24'd0, data}, 32'h99);
    en = 1'b1;
    wait_clk(BIT);

    chk("never_both", n_both, 32'd0);
    chk("busy_low_at_strobe", n_strobe_busy, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
